// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes in_a - in_b - borrow_in one bit per clock, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready and out_valid are pure state decodes and never depend on inputs.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;

  logic accept, step;
  logic bit_a, bit_b, diff_bit, borrow_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && (state_q == IDLE);
  assign step   = (state_q == RUN);

  // Full-subtractor cell applied to the current LSBs.
  assign bit_a       = a_q[0];
  assign bit_b       = b_q[0];
  assign diff_bit    = bit_a ^ bit_b ^ br_q;
  assign borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= in_a;
      b_q   <= in_b;
      r_q   <= '0;
      br_q  <= borrow_in;
      cnt_q <= '0;
    end else if (step) begin
      a_q   <= {1'b0, a_q[WIDTH-1:1]};
      b_q   <= {1'b0, b_q[WIDTH-1:1]};
      r_q   <= {diff_bit, r_q[WIDTH-1:1]};
      br_q  <= borrow_next;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out        = r_q;
  assign borrow_out = br_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, backpressure,
// mid-operation reset and a randomized back-to-back run against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;
  localparam int TIMEOUT = 50;

  logic         clock, reset;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic         borrow_in;
  logic         out_valid, out_ready;
  logic [W-1:0] out;
  logic         borrow_out;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .borrow_out (borrow_out),
    .state_dbg  (state_dbg)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one operation from IDLE; leaves the DUT in DONE (or after a timeout).
  // Returns the number of edges from accept to out_valid.
  task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic bi, input bit jitter, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < TIMEOUT) begin
      @(negedge clock);
      guard++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    borrow_in = bi;
    exp_q.push_back({bi ? (a < b + 9'd1) : (a < b), W'(a - b - W'(bi))});
    @(negedge clock);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      if (jitter) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_a      = W'($urandom_range(0, 255));
        in_b      = W'($urandom_range(0, 255));
        borrow_in = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      lat++;
    end
    in_valid = 1'b0;
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic check_result(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_out"}, 32'(out), 32'(e[W-1:0]));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(e[W]));
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bi, input logic [W-1:0] exp_out, input logic exp_bo);
    int lat;
    start_and_wait(a, b, bi, 1'b0, lat);
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_hand_out"}, 32'(out), 32'(exp_out));
    check({tag, "_hand_borrow"}, 32'(borrow_out), 32'(exp_bo));
    check_result(tag);
    finish_op(tag);
  endtask

  initial begin
    int lat, guard;
    logic [W-1:0] held_out;
    logic         held_bo;
    bit           taken;

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; borrow_in = 1'b0; out_ready = 1'b0;
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    check("reset_borrow", 32'(borrow_out), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Basic with in_ready fall check
    in_valid = 1'b1; in_a = 8'h05; in_b = 8'h03; borrow_in = 1'b0;
    exp_q.push_back({1'b0, 8'h02});
    @(negedge clock);
    in_valid = 1'b0;
    check("basic_in_ready_fall", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(negedge clock);
      lat++;
    end
    check("basic_latency", 32'(lat), 32'd8);
    check("basic_hand_out", 32'(out), 32'h02);
    check_result("basic");
    finish_op("basic");

    directed("underflow", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    directed("zero_bi",   8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    directed("ff_bi",     8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    directed("80_7f",     8'h80, 8'h7F, 1'b0, 8'h01, 1'b0);
    directed("ff_00",     8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);

    // Backpressure with input toggling during RUN and DONE
    start_and_wait(8'hA5, 8'h3C, 1'b1, 1'b1, lat);
    out_ready = 1'b0;
    check("bp_latency", 32'(lat), 32'(W));
    held_out = out;
    held_bo  = borrow_out;
    check("bp_hand_out", 32'(out), 32'h68);
    check("bp_hand_borrow", 32'(borrow_out), 32'd0);
    for (int i = 0; i < 20; i++) begin
      in_valid  = ~in_valid;
      in_a      = W'($urandom_range(0, 255));
      in_b      = W'($urandom_range(0, 255));
      borrow_in = ~borrow_in;
      @(negedge clock);
      check("bp_out_valid_hold", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_stable", 32'(out), 32'(held_out));
      check("bp_borrow_stable", 32'(borrow_out), 32'(held_bo));
    end
    in_valid = 1'b0;
    check_result("bp");
    finish_op("bp");

    // Reset in the middle of an operation
    in_valid = 1'b1; in_a = 8'h10; in_b = 8'h01; borrow_in = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out", 32'(out), 32'd0);
    check("rst_mid_borrow", 32'(borrow_out), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    directed("after_rst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

    // Random back-to-back operations with random out_ready
    for (int n = 0; n < 1000; n++) begin
      start_and_wait(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)), 1'b1, lat);
      if (n < 5) check("rand_latency", 32'(lat), 32'(W));
      check_result("rand");
      taken = 1'b0;
      guard = 0;
      while (!taken && guard < TIMEOUT) begin
        out_ready = 1'($urandom_range(0, 1));
        taken = out_ready;
        @(negedge clock);
        guard++;
      end
      out_ready = 1'b0;
      check("rand_out_valid_drop", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
